// File: rtl/md_pkg.sv
// Shared definitions for the multdiv issue controller: FSM encoding,
// rstatus register, exception codes and the writeback beat layout.
package md_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_t;

    localparam int RSTATUS_REG      = 30;
    localparam int WDOG_MAX_DEFAULT = 63;
    localparam int WDOG_WIDTH       = 6;

    localparam logic [31:0] EXC_MULT    = 32'd4;
    localparam logic [31:0] EXC_DIV     = 32'd5;
    localparam logic [31:0] EXC_TIMEOUT = 32'd6;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exc;
    } md_wb_t;

    // Every exceptional completion writes its code into the rstatus register.
    function automatic md_wb_t exc_beat(input logic [31:0] code, input logic [4:0] rstatus);
        md_wb_t beat;
        beat.rd   = rstatus;
        beat.data = code;
        beat.exc  = 1'b1;
        return beat;
    endfunction

endpackage

// File: rtl/md_watchdog.sv
// Cycle counter bounding how long the issue controller waits on multdiv.
// Terminal count flags the last permitted wait cycle.
module md_watchdog
    import md_pkg::*;
#(
    parameter int MAX = WDOG_MAX_DEFAULT
) (
    input  logic                  clock,
    input  logic                  clrn,
    input  logic                  i_clr,
    input  logic                  i_en,
    output logic [WDOG_WIDTH-1:0] o_count,
    output logic                  o_tc
);

    localparam logic [WDOG_WIDTH-1:0] TC_VALUE = WDOG_WIDTH'(MAX - 1);

    logic [WDOG_WIDTH-1:0] r_count;

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == TC_VALUE);

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issues one multiply/divide to the downstream multdiv unit, waits for its
// ready under a watchdog, and returns a single writeback beat.
module multdiv_issue_ctrl #(
    parameter int WDOG_MAX    = md_pkg::WDOG_MAX_DEFAULT,
    parameter int RSTATUS_REG = md_pkg::RSTATUS_REG
) (
    input  logic        clock,
    input  logic        clrn,
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [31:0] issue_opA,
    input  logic [31:0] issue_opB,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,
    input  logic        flush,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exception,
    output logic        busy
);

    import md_pkg::*;

    localparam logic [4:0] RSTATUS_RD = 5'(RSTATUS_REG);

    md_state_t r_state;
    md_state_t w_nextState;

    logic        r_outEn;
    logic [31:0] r_opA;
    logic [31:0] r_opB;
    logic [4:0]  r_rd;
    logic        r_isDiv;
    logic        r_startMult;
    logic        r_startDiv;
    md_wb_t      r_wb;
    md_wb_t      w_wbNext;

    logic                  w_inIdle;
    logic                  w_accept;
    logic                  w_guard;
    logic                  w_wdogClr;
    logic                  w_wdogEn;
    logic                  w_wdogTc;
    logic [WDOG_WIDTH-1:0] w_wdogCount;

    // issue_ready stays low while clrn is held and rises on the first edge after it.
    assign w_inIdle    = (r_state == ST_IDLE);
    assign issue_ready = r_outEn && w_inIdle;
    assign busy        = !w_inIdle;
    assign w_accept    = issue_valid && issue_ready && !flush;

    assign w_wdogClr = (r_state != ST_WAIT);
    assign w_wdogEn  = (r_state == ST_WAIT);
    assign w_guard   = (w_wdogCount == '0);

    md_watchdog #(
        .MAX (WDOG_MAX)
    ) u_watchdog (
        .clock   (clock),
        .clrn    (clrn),
        .i_clr   (w_wdogClr),
        .i_en    (w_wdogEn),
        .o_count (w_wdogCount),
        .o_tc    (w_wdogTc)
    );

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_state <= ST_IDLE;
            r_outEn <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_outEn <= 1'b1;
        end
    end

    // Ready seen in the guard cycle may belong to the previous operation.
    always_comb begin
        w_nextState = r_state;
        w_wbNext    = r_wb;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_nextState = ST_START;
                end
            end
            ST_START: begin
                w_nextState = flush ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (flush) begin
                    w_nextState = ST_IDLE;
                end else if (!w_guard && md_resultRDY) begin
                    w_nextState = ST_DONE;
                    if (md_exception) begin
                        w_wbNext = exc_beat(r_isDiv ? EXC_DIV : EXC_MULT, RSTATUS_RD);
                    end else begin
                        w_wbNext.rd   = r_rd;
                        w_wbNext.data = md_result;
                        w_wbNext.exc  = 1'b0;
                    end
                end else if (w_wdogTc) begin
                    w_nextState = ST_DONE;
                    w_wbNext    = exc_beat(EXC_TIMEOUT, RSTATUS_RD);
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_opA   <= '0;
            r_opB   <= '0;
            r_rd    <= '0;
            r_isDiv <= 1'b0;
        end else if (w_accept) begin
            r_opA   <= issue_opA;
            r_opB   <= issue_opB;
            r_rd    <= issue_rd;
            r_isDiv <= issue_is_div;
        end
    end

    // The start pulse is registered off the accept so it coincides with START.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_startMult <= 1'b0;
            r_startDiv  <= 1'b0;
        end else begin
            r_startMult <= w_accept && !issue_is_div;
            r_startDiv  <= w_accept && issue_is_div;
        end
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_wb <= '0;
        end else begin
            r_wb <= w_wbNext;
        end
    end

    assign md_operandA  = r_opA;
    assign md_operandB  = r_opB;
    assign md_ctrl_MULT = r_startMult;
    assign md_ctrl_DIV  = r_startDiv;

    assign wb_valid     = (r_state == ST_DONE) && !flush;
    assign wb_rd        = r_wb.rd;
    assign wb_data      = r_wb.data;
    assign wb_exception = r_wb.exc;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Self-checking bench for multdiv_issue_ctrl: directed scenarios plus random
// operations compared against a cycle-count model of the issue protocol.
module tb_multdiv_issue_ctrl;

    localparam int WDOG    = 63;
    localparam int RSTATUS = 30;

    logic        clock;
    logic        clrn;
    logic        issue_valid;
    logic        issue_is_div;
    logic [31:0] issue_opA;
    logic [31:0] issue_opB;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        flush;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_ctrl_MULT;
    logic        md_ctrl_DIV;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;
    logic        busy;

    int assertCount = 0;
    int failCount   = 0;

    // Observations recorded by driveOp, one operation at a time.
    int          obsMult, obsDiv, obsPulseCycle, obsWb, obsWbCycle, obsEndCycle;
    int          obsAcceptWait, obsComplBad, obsOperandBad;
    logic [4:0]  obsWbRd;
    logic [31:0] obsWbData;
    logic        obsWbExc;

    bit          nextIsDiv;
    logic [31:0] nextA, nextB;
    logic [4:0]  nextRd;

    typedef struct {
        int          multPulses;
        int          divPulses;
        int          wbCount;
        int          wbCycle;
        int          endCycle;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exc;
        logic [31:0] mdRes;
        logic        mdExc;
    } expect_t;

    multdiv_issue_ctrl dut (
        .clock        (clock),
        .clrn         (clrn),
        .issue_valid  (issue_valid),
        .issue_is_div (issue_is_div),
        .issue_opA    (issue_opA),
        .issue_opB    (issue_opB),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .flush        (flush),
        .md_operandA  (md_operandA),
        .md_operandB  (md_operandB),
        .md_ctrl_MULT (md_ctrl_MULT),
        .md_ctrl_DIV  (md_ctrl_DIV),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_resultRDY (md_resultRDY),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_exception (wb_exception),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle numbering: cycle 1 is the START cycle right after the accepting edge.
    // Ready first counts in WAIT cycle max(readyFrom,2), and DONE follows it.
    function automatic expect_t modelOp(input bit isDiv, input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] rd, input int readyFrom, input int flushAt);
        expect_t     e;
        logic [63:0] prod;
        bit          exc;
        bit          timeout;
        logic [31:0] res;
        int          doneCycle;
        prod = {32'd0, a} * {32'd0, b};
        if (isDiv) begin
            exc = (b == 32'd0);
            res = exc ? 32'd0 : a / b;
        end else begin
            exc = (prod[63:32] != 32'd0);
            res = prod[31:0];
        end
        timeout      = (readyFrom < 0) || (readyFrom > WDOG);
        doneCycle    = timeout ? WDOG + 2 : ((readyFrom < 2) ? 2 : readyFrom) + 2;
        e.multPulses = isDiv ? 0 : 1;
        e.divPulses  = isDiv ? 1 : 0;
        e.wbCycle    = doneCycle;
        if (flushAt >= 1 && flushAt <= doneCycle) begin
            e.wbCount  = 0;
            e.endCycle = flushAt + 1;
        end else begin
            e.wbCount  = 1;
            e.endCycle = doneCycle + 1;
        end
        if (timeout) begin
            e.rd = 5'(RSTATUS); e.data = 32'd6; e.exc = 1'b1;
        end else if (exc) begin
            e.rd = 5'(RSTATUS); e.data = isDiv ? 32'd5 : 32'd4; e.exc = 1'b1;
        end else begin
            e.rd = rd; e.data = res; e.exc = 1'b0;
        end
        e.mdRes = exc ? (32'hDEAD_BEEF ^ a) : res;
        e.mdExc = exc;
        return e;
    endfunction

    task automatic driveOp(input bit isDiv, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic [31:0] mdRes, input bit mdExc,
                           input int readyFrom, input int flushAt, input bit keepValid);
        obsAcceptWait = 0;
        while (issue_ready !== 1'b1 && obsAcceptWait < 100) begin
            @(posedge clock); #1;
            obsAcceptWait++;
        end
        issue_valid  = 1'b1;
        issue_is_div = isDiv;
        issue_opA    = a;
        issue_opB    = b;
        issue_rd     = rd;
        md_result    = mdRes;
        md_exception = mdExc;
        md_resultRDY = 1'b0;
        flush        = 1'b0;
        obsMult = 0; obsDiv = 0; obsPulseCycle = -1; obsWb = 0; obsWbCycle = -1;
        obsEndCycle = -1; obsComplBad = 0; obsOperandBad = 0;
        obsWbRd = '0; obsWbData = '0; obsWbExc = 1'b0;
        @(posedge clock); #1;
        if (keepValid) begin
            issue_is_div = nextIsDiv;
            issue_opA    = nextA;
            issue_opB    = nextB;
            issue_rd     = nextRd;
        end else begin
            issue_valid = 1'b0;
        end
        for (int c = 1; c <= WDOG + 10; c++) begin
            if (c > 1) begin
                @(posedge clock); #1;
            end
            md_resultRDY = (readyFrom >= 0) && (c - 1 >= readyFrom);
            flush        = (c == flushAt);
            #1;
            if (md_ctrl_MULT === 1'b1) begin
                obsMult++;
                if (obsPulseCycle < 0) obsPulseCycle = c;
            end
            if (md_ctrl_DIV === 1'b1) begin
                obsDiv++;
                if (obsPulseCycle < 0) obsPulseCycle = c;
            end
            if (wb_valid === 1'b1) begin
                obsWb++;
                obsWbCycle = c;
                obsWbRd    = wb_rd;
                obsWbData  = wb_data;
                obsWbExc   = wb_exception;
            end
            if (busy === issue_ready) obsComplBad++;
            if (busy === 1'b1 && (md_operandA !== a || md_operandB !== b)) obsOperandBad++;
            if (c > 1 && issue_ready === 1'b1) begin
                obsEndCycle = c;
                break;
            end
        end
        flush        = 1'b0;
        md_resultRDY = 1'b0;
    endtask

    task automatic test_reset();
        logic [106:0] allOut;
        clrn = 1'b1;
        #1;
        clrn = 1'b0;
        repeat (2) @(negedge clock);
        allOut = {issue_ready, busy, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
                  wb_valid, wb_rd, wb_data, wb_exception};
        assertCount++;
        if (allOut !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: got %h, expected 0", allOut);
        end
        clrn = 1'b1;
        #1;
        assertCount++;
        if (issue_ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_ready_before_edge: got %b, expected 0", issue_ready);
        end
        @(posedge clock); #1;
        assertCount++;
        if (issue_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL reset_ready_after_edge: got %b, expected 1", issue_ready);
        end
        assertCount++;
        if (busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_busy: got %b, expected 0", busy);
        end
    endtask

    task automatic test_multiply();
        expect_t e;
        e = modelOp(1'b0, 32'd7, 32'd6, 5'd5, 3, 0);
        driveOp(1'b0, 32'd7, 32'd6, 5'd5, e.mdRes, e.mdExc, 3, 0, 1'b0);
        assertCount++;
        if (obsMult !== e.multPulses || obsDiv !== e.divPulses) begin
            failCount++;
            $display("[TB] FAIL mult_pulses: got mult=%0d div=%0d, expected mult=%0d div=%0d",
                     obsMult, obsDiv, e.multPulses, e.divPulses);
        end
        assertCount++;
        if (obsPulseCycle !== 1) begin
            failCount++;
            $display("[TB] FAIL mult_pulse_cycle: got %0d, expected 1", obsPulseCycle);
        end
        assertCount++;
        if (obsWb !== e.wbCount || obsWbCycle !== e.wbCycle) begin
            failCount++;
            $display("[TB] FAIL mult_wb_timing: got count=%0d cycle=%0d, expected count=%0d cycle=%0d",
                     obsWb, obsWbCycle, e.wbCount, e.wbCycle);
        end
        assertCount++;
        if (obsWbRd !== e.rd || obsWbData !== e.data || obsWbExc !== e.exc) begin
            failCount++;
            $display("[TB] FAIL mult_wb_value: got rd=%0d data=%0d exc=%b, expected rd=%0d data=%0d exc=%b",
                     obsWbRd, obsWbData, obsWbExc, e.rd, e.data, e.exc);
        end
        assertCount++;
        if (obsComplBad !== 0 || obsOperandBad !== 0) begin
            failCount++;
            $display("[TB] FAIL mult_status: got complement_errs=%0d operand_errs=%0d, expected 0 and 0",
                     obsComplBad, obsOperandBad);
        end
    endtask

    task automatic test_div_by_zero();
        expect_t e;
        e = modelOp(1'b1, 32'd100, 32'd0, 5'd9, 2, 0);
        driveOp(1'b1, 32'd100, 32'd0, 5'd9, e.mdRes, e.mdExc, 2, 0, 1'b0);
        assertCount++;
        if (obsDiv !== e.divPulses || obsMult !== e.multPulses) begin
            failCount++;
            $display("[TB] FAIL div_pulses: got mult=%0d div=%0d, expected mult=%0d div=%0d",
                     obsMult, obsDiv, e.multPulses, e.divPulses);
        end
        assertCount++;
        if (obsWb !== e.wbCount || obsWbCycle !== e.wbCycle) begin
            failCount++;
            $display("[TB] FAIL div0_wb_timing: got count=%0d cycle=%0d, expected count=%0d cycle=%0d",
                     obsWb, obsWbCycle, e.wbCount, e.wbCycle);
        end
        assertCount++;
        if (obsWbRd !== e.rd || obsWbData !== e.data || obsWbExc !== e.exc) begin
            failCount++;
            $display("[TB] FAIL div0_wb_value: got rd=%0d data=%0d exc=%b, expected rd=%0d data=%0d exc=%b",
                     obsWbRd, obsWbData, obsWbExc, e.rd, e.data, e.exc);
        end
    endtask

    task automatic test_stale_ready();
        expect_t e;
        e = modelOp(1'b0, 32'h4000_0000, 32'd4, 5'd11, 0, 0);
        driveOp(1'b0, 32'h4000_0000, 32'd4, 5'd11, e.mdRes, e.mdExc, 0, 0, 1'b0);
        assertCount++;
        if (obsWbCycle !== e.wbCycle || obsWb !== e.wbCount) begin
            failCount++;
            $display("[TB] FAIL stale_guard: got count=%0d cycle=%0d, expected count=%0d cycle=%0d",
                     obsWb, obsWbCycle, e.wbCount, e.wbCycle);
        end
        assertCount++;
        if (obsWbRd !== e.rd || obsWbData !== e.data || obsWbExc !== e.exc) begin
            failCount++;
            $display("[TB] FAIL overflow_wb_value: got rd=%0d data=%0d exc=%b, expected rd=%0d data=%0d exc=%b",
                     obsWbRd, obsWbData, obsWbExc, e.rd, e.data, e.exc);
        end
    endtask

    task automatic test_flush();
        expect_t e;
        e = modelOp(1'b0, 32'd11, 32'd13, 5'd7, 5, 3);
        driveOp(1'b0, 32'd11, 32'd13, 5'd7, e.mdRes, e.mdExc, 5, 3, 1'b0);
        assertCount++;
        if (obsWb !== e.wbCount) begin
            failCount++;
            $display("[TB] FAIL flush_no_wb: got %0d beats, expected %0d", obsWb, e.wbCount);
        end
        assertCount++;
        if (obsEndCycle !== e.endCycle) begin
            failCount++;
            $display("[TB] FAIL flush_idle_cycle: got %0d, expected %0d", obsEndCycle, e.endCycle);
        end
        e = modelOp(1'b1, 32'd1000, 32'd7, 5'd8, 2, 0);
        driveOp(1'b1, 32'd1000, 32'd7, 5'd8, e.mdRes, e.mdExc, 2, 0, 1'b0);
        assertCount++;
        if (obsAcceptWait !== 0 || obsDiv !== 1 || obsPulseCycle !== 1) begin
            failCount++;
            $display("[TB] FAIL flush_reissue: got wait=%0d div=%0d pulse_cycle=%0d, expected 0 1 1",
                     obsAcceptWait, obsDiv, obsPulseCycle);
        end
        assertCount++;
        if (obsWbData !== e.data || obsWbCycle !== e.wbCycle) begin
            failCount++;
            $display("[TB] FAIL flush_reissue_wb: got data=%0d cycle=%0d, expected data=%0d cycle=%0d",
                     obsWbData, obsWbCycle, e.data, e.wbCycle);
        end
    endtask

    task automatic test_back_to_back();
        expect_t e1;
        expect_t e2;
        nextIsDiv = 1'b1;
        nextA     = 32'd1000;
        nextB     = 32'd10;
        nextRd    = 5'd12;
        e1 = modelOp(1'b0, 32'd5, 32'd9, 5'd3, 2, 0);
        e2 = modelOp(nextIsDiv, nextA, nextB, nextRd, 2, 0);
        driveOp(1'b0, 32'd5, 32'd9, 5'd3, e1.mdRes, e1.mdExc, 2, 0, 1'b1);
        assertCount++;
        if (obsMult !== 1 || obsDiv !== 0) begin
            failCount++;
            $display("[TB] FAIL b2b_held_off: got mult=%0d div=%0d, expected mult=1 div=0", obsMult, obsDiv);
        end
        assertCount++;
        if (obsEndCycle !== e1.endCycle || obsComplBad !== 0 || obsOperandBad !== 0) begin
            failCount++;
            $display("[TB] FAIL b2b_first: got end=%0d compl=%0d oper=%0d, expected end=%0d compl=0 oper=0",
                     obsEndCycle, obsComplBad, obsOperandBad, e1.endCycle);
        end
        assertCount++;
        if (obsWbData !== e1.data) begin
            failCount++;
            $display("[TB] FAIL b2b_first_data: got %0d, expected %0d", obsWbData, e1.data);
        end
        driveOp(nextIsDiv, nextA, nextB, nextRd, e2.mdRes, e2.mdExc, 2, 0, 1'b0);
        assertCount++;
        if (obsAcceptWait !== 0 || obsDiv !== 1) begin
            failCount++;
            $display("[TB] FAIL b2b_second_accept: got wait=%0d div=%0d, expected wait=0 div=1",
                     obsAcceptWait, obsDiv);
        end
        assertCount++;
        if (obsWbRd !== e2.rd || obsWbData !== e2.data || obsWbCycle !== e2.wbCycle) begin
            failCount++;
            $display("[TB] FAIL b2b_second_wb: got rd=%0d data=%0d cycle=%0d, expected rd=%0d data=%0d cycle=%0d",
                     obsWbRd, obsWbData, obsWbCycle, e2.rd, e2.data, e2.wbCycle);
        end
    endtask

    task automatic test_timeout();
        expect_t e;
        e = modelOp(1'b0, 32'd3, 32'd3, 5'd17, -1, 0);
        driveOp(1'b0, 32'd3, 32'd3, 5'd17, e.mdRes, e.mdExc, -1, 0, 1'b0);
        assertCount++;
        if (obsWb !== e.wbCount || obsWbCycle !== e.wbCycle) begin
            failCount++;
            $display("[TB] FAIL timeout_timing: got count=%0d cycle=%0d, expected count=%0d cycle=%0d",
                     obsWb, obsWbCycle, e.wbCount, e.wbCycle);
        end
        assertCount++;
        if (obsWbRd !== e.rd || obsWbData !== e.data || obsWbExc !== e.exc) begin
            failCount++;
            $display("[TB] FAIL timeout_wb_value: got rd=%0d data=%0d exc=%b, expected rd=%0d data=%0d exc=%b",
                     obsWbRd, obsWbData, obsWbExc, e.rd, e.data, e.exc);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [106:0] allOut;
        int           wbSeen;
        int           waitCycles;
        waitCycles = 0;
        while (issue_ready !== 1'b1 && waitCycles < 100) begin
            @(posedge clock); #1;
            waitCycles++;
        end
        issue_valid  = 1'b1;
        issue_is_div = 1'b0;
        issue_opA    = 32'd21;
        issue_opB    = 32'd2;
        issue_rd     = 5'd4;
        md_resultRDY = 1'b0;
        @(posedge clock); #1;
        issue_valid = 1'b0;
        repeat (2) begin
            @(posedge clock); #1;
        end
        assertCount++;
        if (busy !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL midreset_in_wait: got busy=%b, expected 1", busy);
        end
        clrn = 1'b0;
        #1;
        allOut = {issue_ready, busy, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
                  wb_valid, wb_rd, wb_data, wb_exception};
        assertCount++;
        if (allOut !== '0) begin
            failCount++;
            $display("[TB] FAIL midreset_outputs: got %h, expected 0", allOut);
        end
        repeat (2) @(negedge clock);
        md_resultRDY = 1'b1;
        clrn         = 1'b1;
        wbSeen       = 0;
        @(posedge clock); #1;
        assertCount++;
        if (issue_ready !== 1'b1 || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midreset_release: got ready=%b busy=%b, expected ready=1 busy=0",
                     issue_ready, busy);
        end
        for (int i = 0; i < 8; i++) begin
            if (wb_valid === 1'b1) wbSeen++;
            @(posedge clock); #1;
        end
        md_resultRDY = 1'b0;
        assertCount++;
        if (wbSeen !== 0) begin
            failCount++;
            $display("[TB] FAIL midreset_no_wb: got %0d beats, expected 0", wbSeen);
        end
    endtask

    task automatic test_random();
        expect_t     e;
        bit          isDiv;
        logic [31:0] a, b;
        logic [4:0]  rd;
        int          readyFrom, flushAt;
        for (int i = 0; i < 25; i++) begin
            isDiv = 1'($urandom_range(0, 1));
            a     = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 65535);
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(0, 65535);
                2:       b = $urandom;
                default: b = $urandom_range(1, 255);
            endcase
            rd        = 5'($urandom_range(1, 31));
            readyFrom = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
            flushAt   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 0;
            e = modelOp(isDiv, a, b, rd, readyFrom, flushAt);
            driveOp(isDiv, a, b, rd, e.mdRes, e.mdExc, readyFrom, flushAt, 1'b0);
            assertCount++;
            if (obsMult !== e.multPulses || obsDiv !== e.divPulses) begin
                failCount++;
                $display("[TB] FAIL rand%0d_pulses: got mult=%0d div=%0d, expected mult=%0d div=%0d",
                         i, obsMult, obsDiv, e.multPulses, e.divPulses);
            end
            assertCount++;
            if (obsWb !== e.wbCount || obsEndCycle !== e.endCycle) begin
                failCount++;
                $display("[TB] FAIL rand%0d_flow: got wb=%0d end=%0d, expected wb=%0d end=%0d",
                         i, obsWb, obsEndCycle, e.wbCount, e.endCycle);
            end
            assertCount++;
            if (obsComplBad !== 0 || obsOperandBad !== 0) begin
                failCount++;
                $display("[TB] FAIL rand%0d_status: got compl=%0d oper=%0d, expected 0 and 0",
                         i, obsComplBad, obsOperandBad);
            end
            if (e.wbCount == 1) begin
                assertCount++;
                if (obsWbCycle !== e.wbCycle || obsWbRd !== e.rd || obsWbData !== e.data || obsWbExc !== e.exc) begin
                    failCount++;
                    $display("[TB] FAIL rand%0d_wb: got cyc=%0d rd=%0d data=%h exc=%b, expected cyc=%0d rd=%0d data=%h exc=%b",
                             i, obsWbCycle, obsWbRd, obsWbData, obsWbExc, e.wbCycle, e.rd, e.data, e.exc);
                end
            end
        end
    endtask

    initial begin
        issue_valid  = 1'b0;
        issue_is_div = 1'b0;
        issue_opA    = '0;
        issue_opB    = '0;
        issue_rd     = '0;
        flush        = 1'b0;
        md_result    = '0;
        md_exception = 1'b0;
        md_resultRDY = 1'b0;
        clrn         = 1'b1;
        $display("[TB] starting multdiv_issue_ctrl bench");
        test_reset();
        test_multiply();
        test_div_by_zero();
        test_stale_ready();
        test_flush();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got no completion, expected finish within time limit");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
